// File: rtl/mem_issue_ctrl_pkg.sv
// ------------------------------------------------------------------
// mem_issue_ctrl_pkg: shared backend types and width helpers. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_issue_ctrl_pkg;

   typedef enum logic [0:0] {
      THR_IDLE   = 1'b0,
      THR_ACTIVE = 1'b1
   } thr_state_e;

   // Index width that never collapses to zero bits for tiny depths.
   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_issue_ctrl_if.sv
// ------------------------------------------------------------------
// mem_issue_ctrl_if: issue-queue / LSU side bus of mem_issue_ctrl. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mem_issue_ctrl_if #(
   parameter int PORTS    = 2,
   parameter int IQ_DEPTH = 8
);
   localparam int IDXW = mem_issue_ctrl_pkg::idx_w(IQ_DEPTH);

   logic [PORTS-1:0]           i_iq_can_issue;
   logic [PORTS-1:0][IDXW-1:0] i_iq_idx;
   logic [PORTS-1:0]           i_i1_cancel;
   logic [PORTS-1:0]           i_i2_replay;
   logic [PORTS-1:0]           i_lsu_stall;
   logic                       i_flush;
   logic [PORTS-1:0]           o_fu_busy;
   logic [PORTS-1:0]           o_issueSuccess;
   logic [PORTS-1:0]           o_issueReplay;
   logic [PORTS-1:0][IDXW-1:0] o_feedbackIdx;

   modport slave (
      input  i_iq_can_issue, i_iq_idx, i_i1_cancel, i_i2_replay, i_lsu_stall, i_flush,
      output o_fu_busy, o_issueSuccess, o_issueReplay, o_feedbackIdx
   );

   modport master (
      output i_iq_can_issue, i_iq_idx, i_i1_cancel, i_i2_replay, i_lsu_stall, i_flush,
      input  o_fu_busy, o_issueSuccess, o_issueReplay, o_feedbackIdx
   );

endinterface

`default_nettype wire

// File: rtl/mem_issue_throttle.sv
// ------------------------------------------------------------------
// mem_issue_throttle: consecutive-replay counter and throttle-window FSM. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_issue_throttle
   import mem_issue_ctrl_pkg::*;
#(
   parameter int REPLAY_MAX      = 4,
   parameter int THROTTLE_CYCLES = 4,
   parameter int CNTW            = $clog2(REPLAY_MAX + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_any_replay,
   input  logic            i_any_success,
   input  logic            i_flush,
   output logic            o_throttle,
   output logic [CNTW-1:0] o_count
);

   localparam int            WINW       = idx_w(THROTTLE_CYCLES);
   localparam logic [CNTW-1:0] C_CNT_MAX  = CNTW'(REPLAY_MAX);
   localparam logic [WINW-1:0] C_WIN_LOAD = WINW'(THROTTLE_CYCLES - 1);

   thr_state_e      r_state;
   thr_state_e      w_state_nxt;
   logic [CNTW-1:0] r_cnt;
   logic [CNTW-1:0] w_cnt_nxt;
   logic [CNTW-1:0] w_cnt_inc;
   logic [WINW-1:0] r_win;
   logic [WINW-1:0] w_win_nxt;

   always_ff @(posedge clk) begin
      if (!rst || i_flush) begin
         r_state <= THR_IDLE;
         r_cnt   <= '0;
         r_win   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_win   <= w_win_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_win_nxt   = r_win;
      w_cnt_inc   = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNTW'(1);
      case (r_state)
         THR_IDLE: begin
            if (i_any_replay) begin
               w_cnt_nxt = w_cnt_inc;
            end else if (i_any_success) begin
               w_cnt_nxt = '0;
            end
            if (w_cnt_nxt == C_CNT_MAX) begin
               w_state_nxt = THR_ACTIVE;
               w_cnt_nxt   = '0;
               w_win_nxt   = C_WIN_LOAD;
            end
         end
         THR_ACTIVE: begin
            // Replays seen during the window do not count toward a new trigger.
            w_cnt_nxt = '0;
            if (r_win == '0) begin
               w_state_nxt = THR_IDLE;
            end else begin
               w_win_nxt = r_win - WINW'(1);
            end
         end
         default: begin
            w_state_nxt = THR_IDLE;
            w_cnt_nxt   = '0;
            w_win_nxt   = '0;
         end
      endcase
   end

   assign o_throttle = (r_state == THR_ACTIVE);
   assign o_count    = r_cnt;

endmodule

`default_nettype wire

// File: rtl/mem_issue_ctrl.sv
// ------------------------------------------------------------------
// mem_issue_ctrl: tracks i1/i2 issue, returns success/replay verdicts, drives FU busy. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_issue_ctrl
   import mem_issue_ctrl_pkg::*;
#(
   parameter int PORTS           = 2,
   parameter int IQ_DEPTH        = 8,
   parameter int REPLAY_MAX      = 4,
   parameter int THROTTLE_CYCLES = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   mem_issue_ctrl_if.slave                    bus,
   output logic                               o_throttle,
   output logic [$clog2(REPLAY_MAX + 1)-1:0]  o_replay_cnt
);

   localparam int IDXW = idx_w(IQ_DEPTH);
   localparam int CNTW = $clog2(REPLAY_MAX + 1);

   logic [PORTS-1:0]           r_busy_q;
   logic [PORTS-1:0]           w_accept;
   logic [PORTS-1:0]           w_busy;
   logic [PORTS-1:0]           w_success;
   logic [PORTS-1:0]           w_replay;
   logic [PORTS-1:0][IDXW-1:0] w_fb_idx;
   logic                       w_throttle;
   logic [CNTW-1:0]            w_count;

   // A port that was busy last cycle may still show a stale queue valid; drop it.
   assign w_accept = bus.i_iq_can_issue & ~r_busy_q;
   assign w_busy   = bus.i_lsu_stall | {PORTS{w_throttle}};

   always_ff @(posedge clk) begin
      if (!rst || bus.i_flush) begin
         r_busy_q <= '0;
      end else begin
         r_busy_q <= w_busy;
      end
   end

   for (genvar p = 0; p < PORTS; p++) begin : g_port
      logic            r_vld;
      logic            r_canc;
      logic [IDXW-1:0] r_idx;
      logic            w_vrd;
      logic            w_rep;

      always_ff @(posedge clk) begin
         if (!rst || bus.i_flush) begin
            r_vld  <= 1'b0;
            r_canc <= 1'b0;
            r_idx  <= '0;
         end else begin
            r_vld  <= w_accept[p];
            r_canc <= bus.i_i1_cancel[p];
            r_idx  <= bus.i_iq_idx[p];
         end
      end

      assign w_vrd        = r_vld & ~bus.i_flush & rst;
      assign w_rep        = r_canc | bus.i_i2_replay[p];
      assign w_replay[p]  = w_vrd & w_rep;
      assign w_success[p] = w_vrd & ~w_rep;
      assign w_fb_idx[p]  = w_vrd ? r_idx : '0;
   end

   mem_issue_throttle #(
      .REPLAY_MAX      (REPLAY_MAX),
      .THROTTLE_CYCLES (THROTTLE_CYCLES),
      .CNTW            (CNTW)
   ) u_throttle (
      .clk           (clk),
      .rst           (rst),
      .i_any_replay  (|w_replay),
      .i_any_success (|w_success),
      .i_flush       (bus.i_flush),
      .o_throttle    (w_throttle),
      .o_count       (w_count)
   );

   assign bus.o_fu_busy      = w_busy;
   assign bus.o_issueSuccess = w_success;
   assign bus.o_issueReplay  = w_replay;
   assign bus.o_feedbackIdx  = w_fb_idx;
   assign o_throttle         = w_throttle;
   assign o_replay_cnt       = w_count;

endmodule

`default_nettype wire
